// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
  localparam int         DEFAULT_TIMEOUT = 255;

  // Any set low address bit makes a word access illegal.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_access_unit_mem_wb_reg.sv
// MEM/WB pipeline register: loads every cycle, or inserts a bubble while the
// stage is stalled (control bits cleared, data fields held).
module mem_wb_reg
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble,
  input  logic        reg_write_i,
  input  logic        mem_to_reg_i,
  input  logic [31:0] rd_data_i,
  input  logic [31:0] alu_i,
  input  logic [4:0]  wn_i,
  output logic        reg_write_o,
  output logic        mem_to_reg_o,
  output logic [31:0] rd_data_o,
  output logic [31:0] alu_o,
  output logic [4:0]  wn_o
);

  logic        reg_write_q, reg_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  wn_q, wn_d;

  // Next-value select: bubble clears control, otherwise take the new fields.
  always_comb begin
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    rd_data_d    = rd_data_q;
    alu_d        = alu_q;
    wn_d         = wn_q;
    if (bubble) begin
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else begin
      reg_write_d  = reg_write_i;
      mem_to_reg_d = mem_to_reg_i;
      rd_data_d    = rd_data_i;
      alu_d        = alu_i;
      wn_d         = wn_i;
    end
  end

  // Register update with synchronous reset to an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      rd_data_q    <= '0;
      alu_q        <= '0;
      wn_q         <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      rd_data_q    <= rd_data_d;
      alu_q        <= alu_d;
      wn_q         <= wn_d;
    end
  end

  assign reg_write_o  = reg_write_q;
  assign mem_to_reg_o = mem_to_reg_q;
  assign rd_data_o    = rd_data_q;
  assign alu_o        = alu_q;
  assign wn_o         = wn_q;

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage engine: issues word loads/stores over a req/ack bus, stalls the
// upstream pipeline while an access is in flight, and owns the MEM/WB register.
//
// state | meaning
// IDLE  | no access in flight; aligned memop starts one, others pass through
// REQ   | bus_req_o held with stable addr/we/wdata until ack or timeout
// DONE  | access finished; one non-stalled cycle so EX/MEM advances
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_write_i,
  input  logic        mem_to_reg_i,
  input  logic        mem_write_i,
  input  logic        mem_read_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] wd_i,
  input  logic [4:0]  wn_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic        reg_write_o,
  output logic        mem_to_reg_o,
  output logic [31:0] rd_data_o,
  output logic [31:0] alu_o,
  output logic [4:0]  wn_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic              misal_flag_q, misal_flag_d;
  logic              to_flag_q, to_flag_d;

  logic memop;
  logic misal;
  logic drop_wb;

  assign memop = mem_read_i | mem_write_i;
  assign misal = memop & is_misaligned(alu_i);

  // Sequencing of one bus access plus the sticky error flags.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    cnt_d        = cnt_q;
    abort_d      = abort_q;
    misal_flag_d = misal_flag_q;
    to_flag_d    = to_flag_q;
    case (state_q)
      IDLE: begin
        if (misal) begin
          misal_flag_d = 1'b1;
        end else if (memop) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = mem_write_i;
          addr_d  = {alu_i[31:2], 2'b00};
          wdata_d = wd_i;
          cnt_d   = '0;
          abort_d = 1'b0;
        end
      end
      REQ: begin
        // Ack wins over timeout when both land on the same cycle.
        if (bus_ack_i) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (!we_q) rbuf_d = bus_rdata_i;
        end else if (cnt_q == TO_CNT) begin
          state_d   = DONE;
          req_d     = 1'b0;
          abort_d   = 1'b1;
          to_flag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and bus-side registers, synchronous reset abandons any access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      cnt_q        <= '0;
      abort_q      <= 1'b0;
      misal_flag_q <= 1'b0;
      to_flag_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
      misal_flag_q <= misal_flag_d;
      to_flag_q    <= to_flag_d;
    end
  end

  // Stall covers the issuing IDLE cycle and every REQ cycle, never DONE,
  // so a serviced op leaves EX/MEM at the end of DONE and is not re-issued.
  assign stall_o = ((state_q == IDLE) & memop & ~misal) | (state_q == REQ);

  // Misaligned ops and aborted loads must not write the register file.
  assign drop_wb = misal | ((state_q == DONE) & abort_q & mem_read_i);

  mem_wb_reg u_mem_wb (
    .clk          (clk),
    .rst          (rst),
    .bubble       (stall_o),
    .reg_write_i  (reg_write_i & ~drop_wb),
    .mem_to_reg_i (mem_to_reg_i),
    .rd_data_i    (rbuf_q),
    .alu_i        (alu_i),
    .wn_i         (wn_i),
    .reg_write_o  (reg_write_o),
    .mem_to_reg_o (mem_to_reg_o),
    .rd_data_o    (rd_data_o),
    .alu_o        (alu_o),
    .wn_o         (wn_o)
  );

  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign misalign_o  = misal_flag_q;
  assign timeout_o   = to_flag_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed ops, per-cycle compare against an
// op-level model, plus literal spot checks.
module tb_dmem_access_unit;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_write_i = 0, mem_to_reg_i = 0, mem_write_i = 0, mem_read_i = 0;
  logic [31:0] alu_i = '0, wd_i = '0;
  logic [4:0]  wn_i = '0;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic        bus_ack_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        stall_o, reg_write_o, mem_to_reg_o;
  logic [31:0] rd_data_o, alu_o;
  logic [4:0]  wn_o;
  logic        misalign_o, timeout_o;

  dmem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i),
    .mem_write_i(mem_write_i), .mem_read_i(mem_read_i),
    .alu_i(alu_i), .wd_i(wd_i), .wn_i(wn_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .stall_o(stall_o), .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
    .rd_data_o(rd_data_o), .alu_o(alu_o), .wn_o(wn_o),
    .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 0;
  int stall_seen = 0;
  int req_seen = 0;

  // Model expectations for the current cycle.
  logic        exp_stall = 0, exp_req = 0, exp_we = 0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic        exp_rw = 0, exp_mtr = 0, exp_mis = 0, exp_to = 0;
  logic [31:0] exp_rd = '0, exp_alu = '0, rbuf_m = '0;
  logic [4:0]  exp_wn = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      if (stall_o) stall_seen++;
      if (bus_req_o) req_seen++;
      chk("stall", {31'b0, stall_o}, {31'b0, exp_stall});
      chk("bus_req", {31'b0, bus_req_o}, {31'b0, exp_req});
      chk("bus_we", {31'b0, bus_we_o}, {31'b0, exp_we});
      chk("bus_addr", bus_addr_o, exp_addr);
      chk("bus_wdata", bus_wdata_o, exp_wdata);
      chk("reg_write", {31'b0, reg_write_o}, {31'b0, exp_rw});
      chk("mem_to_reg", {31'b0, mem_to_reg_o}, {31'b0, exp_mtr});
      chk("rd_data", rd_data_o, exp_rd);
      chk("alu", alu_o, exp_alu);
      chk("wn", {27'b0, wn_o}, {27'b0, exp_wn});
      chk("misalign", {31'b0, misalign_o}, {31'b0, exp_mis});
      chk("timeout", {31'b0, timeout_o}, {31'b0, exp_to});
    end
  end

  // One op held in EX/MEM until the stage releases it. ack_d = REQ-cycle index
  // of the ack (negative = never); stray adds acks outside REQ.
  task automatic run_op(input logic rw, input logic mtr, input logic mw, input logic mr,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wn,
                        input int ack_d, input logic [31:0] rdata, input logic stray);
    logic memop, mis, to_;
    int nreq, nst;
    memop = mw | mr;
    mis   = memop && (alu[1:0] != 2'b00);
    to_   = memop && !mis && (ack_d < 0 || ack_d > TIMEOUT);
    nreq  = (!memop || mis) ? 0 : (to_ ? TIMEOUT + 1 : ack_d + 1);
    nst   = (nreq == 0) ? 0 : nreq + 1;
    stall_seen = 0;
    req_seen   = 0;
    for (int k = 0; k <= nst; k++) begin
      if (k > 0) begin
        exp_rw  = 1'b0;
        exp_mtr = 1'b0;
      end
      if (k == 1) begin
        exp_we    = mw;
        exp_addr  = alu & ~32'h3;
        exp_wdata = wd;
      end
      if (k == nst && k > 0 && to_) exp_to = 1'b1;
      reg_write_i  = rw;
      mem_to_reg_i = mtr;
      mem_write_i  = mw;
      mem_read_i   = mr;
      alu_i        = alu;
      wd_i         = wd;
      wn_i         = wn;
      bus_ack_i    = (nreq > 0 && !to_ && k == 1 + ack_d) || (stray && (k == 0 || k == nst));
      bus_rdata_i  = bus_ack_i ? rdata : 32'hDEADBEEF;
      exp_stall    = (k < nst);
      exp_req      = (k >= 1 && k <= nreq);
      @(posedge clk); #1;
    end
    bus_ack_i = 1'b0;
    if (memop && !mis && mr && !to_) rbuf_m = rdata;
    exp_rw  = rw && !mis && !(mr && to_);
    exp_mtr = mtr;
    exp_rd  = rbuf_m;
    exp_alu = alu;
    exp_wn  = wn;
    if (mis) exp_mis = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_reg_write", {31'b0, reg_write_o}, 32'h0);
    chk("rst_bus_req", {31'b0, bus_req_o}, 32'h0);
    chk("rst_alu", alu_o, 32'h0);
    chk_en = 1;

    // non-memory pass-through
    run_op(1, 0, 0, 0, 32'h10, 32'h0, 5'd5, -1, 32'h0, 0);
    chk("nop_rw", {31'b0, reg_write_o}, 32'h1);
    chk("nop_alu", alu_o, 32'h10);
    chk("nop_wn", {27'b0, wn_o}, 32'd5);
    chk("nop_stall_cnt", stall_seen, 0);

    // load, ack in second REQ cycle
    run_op(1, 1, 0, 1, 32'h100, 32'h0, 5'd7, 1, 32'hCAFEF00D, 0);
    chk("ld_rd", rd_data_o, 32'hCAFEF00D);
    chk("ld_mtr", {31'b0, mem_to_reg_o}, 32'h1);
    chk("ld_rw", {31'b0, reg_write_o}, 32'h1);
    chk("ld_stall_cnt", stall_seen, 3);
    chk("ld_req_cnt", req_seen, 2);

    // store, immediate ack; read data on the bus must not be captured
    run_op(0, 0, 1, 0, 32'h200, 32'h12345678, 5'd0, 0, 32'h77777777, 0);
    chk("st_stall_cnt", stall_seen, 2);
    chk("st_wdata", bus_wdata_o, 32'h12345678);
    chk("st_we", {31'b0, bus_we_o}, 32'h1);

    // misaligned load
    run_op(1, 1, 0, 1, 32'h102, 32'h0, 5'd8, 0, 32'h11111111, 0);
    chk("mis_flag", {31'b0, misalign_o}, 32'h1);
    chk("mis_rw", {31'b0, reg_write_o}, 32'h0);
    chk("mis_req_cnt", req_seen, 0);

    // stray ack on a non-memory op
    run_op(1, 0, 0, 0, 32'h44, 32'h0, 5'd4, -1, 32'h0, 1);

    // ack on the cycle the counter reaches TIMEOUT still succeeds
    run_op(1, 1, 0, 1, 32'h104, 32'h0, 5'd9, TIMEOUT, 32'h0BADC0DE, 0);
    chk("edge_rd", rd_data_o, 32'h0BADC0DE);
    chk("edge_to", {31'b0, timeout_o}, 32'h0);

    // load never acked, stray acks before and after REQ
    run_op(1, 1, 0, 1, 32'h400, 32'h0, 5'd10, -1, 32'h22222222, 1);
    chk("to_flag", {31'b0, timeout_o}, 32'h1);
    chk("to_rw", {31'b0, reg_write_o}, 32'h0);
    chk("to_req_cnt", req_seen, TIMEOUT + 1);
    chk("to_stall_cnt", stall_seen, TIMEOUT + 2);

    // misaligned store, then a plain ALU op
    run_op(0, 0, 1, 0, 32'h203, 32'hFFFF0000, 5'd0, 0, 32'h0, 0);
    run_op(1, 0, 0, 0, 32'hABCD, 32'h0, 5'd31, -1, 32'h0, 0);

    // reset in the middle of REQ
    reg_write_i = 1; mem_to_reg_i = 1; mem_read_i = 1; mem_write_i = 0;
    alu_i = 32'h300; wd_i = 32'h0; wn_i = 5'd3; bus_ack_i = 0;
    exp_stall = 1; exp_req = 0;
    @(posedge clk); #1;
    exp_rw = 0; exp_mtr = 0; exp_we = 0; exp_addr = 32'h300; exp_wdata = 32'h0;
    exp_req = 1; exp_stall = 1;
    @(posedge clk); #1;
    rst = 1;
    reg_write_i = 0; mem_to_reg_i = 0; mem_read_i = 0; alu_i = 0; wn_i = 0;
    @(posedge clk); #1;
    rst = 0;
    exp_stall = 0; exp_req = 0; exp_we = 0; exp_addr = 0; exp_wdata = 0;
    exp_rw = 0; exp_mtr = 0; exp_rd = 0; exp_alu = 0; exp_wn = 0;
    exp_mis = 0; exp_to = 0; rbuf_m = 0;
    chk("rst_mid_req", {31'b0, bus_req_o}, 32'h0);
    chk("rst_mid_to", {31'b0, timeout_o}, 32'h0);
    chk("rst_mid_mis", {31'b0, misalign_o}, 32'h0);
    bus_ack_i = 1; bus_rdata_i = 32'h99999999;
    @(posedge clk); #1;
    bus_ack_i = 0;

    // normal operation after reset
    run_op(1, 1, 0, 1, 32'h500, 32'h0, 5'd12, 0, 32'h55AA55AA, 0);
    chk("post_rst_rd", rd_data_o, 32'h55AA55AA);
    run_op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, -1, 32'h0, 0);
    @(negedge clk);
    chk_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
